pipeline_hazard_unit: RTL and testbench
=======================================

// Module: pipeline_hazard_unit
// PURPOSE
// Parametrised scoreboard for the in-order pipeline that merges hazard detection and operand forwarding.
// Tracks destination registers of in-flight instructions from EX through WB. Stalls ID on load-use hazards.
// Registers per-operand forward selects into EX and muxes forwarded data.
// Also flushes on branch, freezes on memory wait, and counts stalls/forwards for performance monitoring.
// PARAMETERS
// DATA_W      16  operand/result width
// REG_AW      3   register address width
// NUM_SRC     2   source operands per instruction
// DEPTH       3   tracked stages after ID: 1=EX, 2=MEM, 3=WB; legal range 2..6
// LOAD_RDY    3   first stage whose result is valid for a load (ALU results valid from stage 2)
// CNT_W       16  performance counter width
// PORTS
// clock         in   1              sole clock, rising edge
// reset         in   1              synchronous, active-high
// id_valid      in   1              ID holds a real instruction
// id_src        in   NUM_SRC*REG_AW source register addresses; operand i occupies [i*REG_AW +: REG_AW]
// id_src_used   in   NUM_SRC        bit i = operand i reads a register
// id_dst        in   REG_AW         destination register
// id_dst_wr     in   1              instruction writes id_dst
// id_is_load    in   1              result only valid from stage LOAD_RDY
// flush_id      in   1              kill instruction in ID (taken branch)
// freeze        in   1              hold all tracked stages (memory wait)
// ex_opnd_in    in   NUM_SRC*DATA_W register-file operands latched into EX
// stage_result  in   DEPTH*DATA_W   result of stage k at [(k-1)*DATA_W +: DATA_W]; entry k=1 is unused
// stall         out  1              hold PC and IF/ID; insert bubble into EX
// fwd_sel       out  NUM_SRC*SEL_W  per-operand EX source: 0 = ex_opnd_in, k = stage k; SEL_W = $clog2(DEPTH+1)
// ex_opnd       out  NUM_SRC*DATA_W forwarded operands for the ALU
// stall_cnt     out  CNT_W          saturating count of stall cycles
// fwd_cnt       out  CNT_W          saturating count of forwarded operands
// BEHAVIOUR
// - Scoreboard entry sb[k], k=1..DEPTH, holds {vld, wr, dst, ld} for the instruction currently in stage k.
// - Reset values: all sb entries invalid; fwd_sel = 0; stall_cnt = 0; fwd_cnt = 0.
//   stall is combinational, so it reads 0 while the scoreboard is empty.
// - Match for operand i at sb[k], k<DEPTH: vld & wr & id_src_used[i] & (dst == src_i).
//   Youngest match, i.e. smallest k, wins.
// - Hazard: a matching load at sb[k] with k+1 < LOAD_RDY; at defaults only a load in EX stalls.
//   A matching ALU op can always forward because k+1 >= 2.
//   A match at sb[DEPTH] is committed: the register file must write-before-read. Select 0.
// - stall = id_valid & ~flush_id & ~freeze & hazard on any operand. It is combinational from sb and the ID inputs.
// - Event priority on each rising edge: reset > freeze > flush_id > stall > advance.
//   freeze: sb, fwd_sel and the counters hold. stall is forced low.
//   flush_id: sb shifts; sb[1] becomes a bubble; fwd_sel <= 0.
//   stall: sb shifts; sb[1] becomes a bubble; fwd_sel <= 0; stall_cnt increments.
//   advance: sb shifts; sb[1] <= ID fields, with vld = id_valid; fwd_sel[i] <= (youngest match k) + 1, or 0.
//     fwd_cnt adds the number of nonzero new selects.
// - Shift: sb[k+1] <= sb[k]; the WB entry drops out. Latency is 1 cycle from ID decision to fwd_sel/ex_opnd in EX.
// - ex_opnd[i] is combinational: fwd_sel[i] == 0 ? ex_opnd_in[i] : stage_result[fwd_sel[i]].
// - Counters saturate at all-ones and never wrap.
// - Reset mid-stall releases stall in the same cycle, because the scoreboard is empty.
// - A flush coincident with a hazard yields no stall.
// STRUCTURE
// - Shared package: stage index constants (STG_EX=1, STG_MEM=2, STG_WB=3), the sel encoding (SEL_RF=0), SEL_W.
// - One sub-module, fwd_operand_mux: DATA_W/DEPTH mux for a single operand. Instantiate it NUM_SRC times.
// - Scoreboard, stall logic and counters stay in this module.
// TESTING
// 1 ALU chain: add r1 at ID, then r2=r1+r3 next cycle -> stall=0; fwd_sel[0]=2; ex_opnd[0]=stage_result[2]=0x0042.
// 2 Load-use: load r4, then use r4 -> stall=1 for exactly 1 cycle; stall_cnt=1; then fwd_sel=3; ex_opnd=stage_result[3].
// 3 Youngest wins: r5 written by two consecutive ALU ops, then read -> fwd_sel=2, not 3.
// 4 Flush with hazard: load r4 in EX; use r4 in ID with flush_id=1 -> stall=0; sb[1] becomes a bubble; fwd_sel=0.
// 5 Freeze for 3 cycles during a load-use -> sb, fwd_sel and counters unchanged; stall=0; on release stall=1 once.
// 6 Reset asserted while stall=1 -> next cycle stall=0, fwd_sel=0, counters=0.
//   Counter saturation: preload fwd_cnt=0xFFFF -> stays 0xFFFF.

Source files
------------

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared constants for the hazard/forwarding scoreboard: stage indices,
// forward-select encoding and the per-edge event priority.
package pipeline_hazard_unit_pkg;

   localparam int STG_EX  = 1;
   localparam int STG_MEM = 2;
   localparam int STG_WB  = 3;

   localparam int SEL_RF  = 0;

   function automatic int sel_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int SEL_W = sel_w(STG_WB);

   typedef enum logic [2:0] {
      EV_RESET,
      EV_FREEZE,
      EV_FLUSH,
      EV_STALL,
      EV_ADVANCE
   } sb_event_e;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// ID/EX-side bundle between the pipeline control and the hazard unit.
interface pipeline_hazard_unit_if
   import pipeline_hazard_unit_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int REG_AW  = 3,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int CNT_W   = 16
);
   localparam int FS_W = sel_w(DEPTH);

   logic                      id_valid;
   logic [NUM_SRC*REG_AW-1:0] id_src;
   logic [NUM_SRC-1:0]        id_src_used;
   logic [REG_AW-1:0]         id_dst;
   logic                      id_dst_wr;
   logic                      id_is_load;
   logic                      flush_id;
   logic                      freeze;
   logic [NUM_SRC*DATA_W-1:0] ex_opnd_in;
   logic [DEPTH*DATA_W-1:0]   stage_result;
   logic                      stall;
   logic [NUM_SRC*FS_W-1:0]   fwd_sel;
   logic [NUM_SRC*DATA_W-1:0] ex_opnd;
   logic [CNT_W-1:0]          stall_cnt;
   logic [CNT_W-1:0]          fwd_cnt;

   modport master (
      output id_valid, id_src, id_src_used, id_dst, id_dst_wr, id_is_load,
             flush_id, freeze, ex_opnd_in, stage_result,
      input  stall, fwd_sel, ex_opnd, stall_cnt, fwd_cnt
   );

   modport slave (
      input  id_valid, id_src, id_src_used, id_dst, id_dst_wr, id_is_load,
             flush_id, freeze, ex_opnd_in, stage_result,
      output stall, fwd_sel, ex_opnd, stall_cnt, fwd_cnt
   );

endinterface

// File: rtl/pipeline_hazard_unit_fwd_operand_mux.sv
// Single-operand forwarding mux: select 0 takes the register-file value,
// select k takes the result currently in stage k.
module fwd_operand_mux
   import pipeline_hazard_unit_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 3
) (
   input  logic [sel_w(DEPTH)-1:0] sel,
   input  logic [DATA_W-1:0]       rf_opnd,
   input  logic [DEPTH*DATA_W-1:0] stage_result,
   output logic [DATA_W-1:0]       opnd
);
   localparam int FS_W = sel_w(DEPTH);

   always_comb begin
      opnd = rf_opnd;
      for (int k = 1; k <= DEPTH; k++) begin
         if (sel == FS_W'(k)) opnd = stage_result[(k-1)*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// In-order pipeline scoreboard: load-use stall detection, per-operand forward
// select registered into EX, forwarded operand muxing and perf counters.
module pipeline_hazard_unit
   import pipeline_hazard_unit_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int REG_AW   = 3,
   parameter int NUM_SRC  = 2,
   parameter int DEPTH    = STG_WB,
   parameter int LOAD_RDY = STG_WB,
   parameter int CNT_W    = 16
) (
   input logic              clock,
   input logic              reset,
   pipeline_hazard_unit_if.slave hu
);
   localparam int FS_W = sel_w(DEPTH);
   localparam int N_W  = $clog2(NUM_SRC + 1);

   logic [DEPTH:1]                   sb_vld, sb_wr, sb_ld;
   logic [DEPTH:1][REG_AW-1:0]       sb_dst;
   logic [NUM_SRC-1:0][FS_W-1:0]     sel_q, sel_nxt;
   logic [NUM_SRC-1:0]               haz;
   logic [N_W-1:0]                   n_fwd;
   logic [CNT_W-1:0]                 stall_cnt_q, fwd_cnt_q;
   logic [NUM_SRC-1:0][DATA_W-1:0]   ex_opnd;
   logic                             stall;
   sb_event_e                        ev;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [N_W-1:0]   b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   // Walk oldest to youngest so the youngest match overrides. A WB match is
   // already committed to the register file, so it maps to the RF select.
   always_comb begin
      sel_nxt = '0;
      haz     = '0;
      n_fwd   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = DEPTH; k >= 1; k--) begin
            if (sb_vld[k] && sb_wr[k] && hu.id_src_used[i] &&
                sb_dst[k] == hu.id_src[i*REG_AW +: REG_AW]) begin
               sel_nxt[i] = (k == DEPTH) ? FS_W'(SEL_RF) : FS_W'(k + 1);
               haz[i]     = (k + 1) < (sb_ld[k] ? LOAD_RDY : STG_MEM);
            end
         end
         if (sel_nxt[i] != FS_W'(SEL_RF)) n_fwd = n_fwd + N_W'(1);
      end
   end

   assign stall = hu.id_valid & ~hu.flush_id & ~hu.freeze & (|haz);

   always_comb begin
      if (reset)            ev = EV_RESET;
      else if (hu.freeze)   ev = EV_FREEZE;
      else if (hu.flush_id) ev = EV_FLUSH;
      else if (stall)       ev = EV_STALL;
      else                  ev = EV_ADVANCE;
   end

   always_ff @(posedge clock) begin
      case (ev)
         EV_RESET: begin
            sb_vld      <= '0;
            sb_wr       <= '0;
            sb_ld       <= '0;
            sb_dst      <= '0;
            sel_q       <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
         end
         EV_FREEZE: ;
         default: begin
            sb_vld[DEPTH:2] <= sb_vld[DEPTH-1:1];
            sb_wr[DEPTH:2]  <= sb_wr[DEPTH-1:1];
            sb_ld[DEPTH:2]  <= sb_ld[DEPTH-1:1];
            sb_dst[DEPTH:2] <= sb_dst[DEPTH-1:1];
            if (ev == EV_ADVANCE) begin
               sb_vld[STG_EX] <= hu.id_valid;
               sb_wr[STG_EX]  <= hu.id_dst_wr;
               sb_ld[STG_EX]  <= hu.id_is_load;
               sb_dst[STG_EX] <= hu.id_dst;
               sel_q          <= sel_nxt;
               fwd_cnt_q      <= sat_add(fwd_cnt_q, n_fwd);
            end else begin
               // Flush and stall both inject a bubble into EX.
               sb_vld[STG_EX] <= 1'b0;
               sb_wr[STG_EX]  <= 1'b0;
               sb_ld[STG_EX]  <= 1'b0;
               sb_dst[STG_EX] <= '0;
               sel_q          <= '0;
               if (ev == EV_STALL) stall_cnt_q <= sat_add(stall_cnt_q, N_W'(1));
            end
         end
      endcase
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_mux
      fwd_operand_mux #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mux (
         .sel          (sel_q[i]),
         .rf_opnd      (hu.ex_opnd_in[i*DATA_W +: DATA_W]),
         .stage_result (hu.stage_result),
         .opnd         (ex_opnd[i])
      );
   end

   assign hu.stall     = stall;
   assign hu.fwd_sel   = sel_q;
   assign hu.ex_opnd   = ex_opnd;
   assign hu.stall_cnt = stall_cnt_q;
   assign hu.fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: forwarding, load-use stall, flush,
// freeze, reset release and counter saturation with hand-computed values.
module tb_pipeline_hazard_unit;
   import pipeline_hazard_unit_pkg::*;

   logic clock = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   pipeline_hazard_unit_if hu ();

   pipeline_hazard_unit dut (
      .clock (clock),
      .reset (reset),
      .hu    (hu)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic id_set(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [1:0] used, input logic [2:0] dst,
                         input logic wr, input logic ld);
      hu.id_valid    = v;
      hu.id_src      = {s1, s0};
      hu.id_src_used = used;
      hu.id_dst      = dst;
      hu.id_dst_wr   = wr;
      hu.id_is_load  = ld;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      hu.flush_id     = 1'b0;
      hu.freeze       = 1'b0;
      hu.ex_opnd_in   = {16'h2000, 16'h1000};
      hu.stage_result = {16'h0043, 16'h0042, 16'h0041};
      id_set(0, 0, 0, 2'b00, 0, 0, 0);
      tick();
      tick();
      chk("rst_stall", hu.stall, 0);
      chk("rst_sel", hu.fwd_sel, 0);
      chk("rst_scnt", hu.stall_cnt, 0);
      chk("rst_fcnt", hu.fwd_cnt, 0);
      reset = 1'b0;

      // ALU chain: add r1; r2 = r1 + r3
      id_set(1, 0, 0, 2'b00, 1, 1, 0); tick();
      id_set(1, 1, 3, 2'b11, 2, 1, 0); #1;
      chk("t1_stall", hu.stall, 0);
      tick();
      chk("t1_sel", hu.fwd_sel, 4'h2);
      chk("t1_opnd0", hu.ex_opnd[15:0], 16'h0042);
      chk("t1_opnd1", hu.ex_opnd[31:16], 16'h2000);
      chk("t1_fcnt", hu.fwd_cnt, 1);

      // Load-use: load r4; use r4
      id_set(1, 0, 0, 2'b00, 4, 1, 1); tick();
      id_set(1, 4, 0, 2'b01, 5, 1, 0); #1;
      chk("t2_stall", hu.stall, 1);
      tick();
      chk("t2_scnt", hu.stall_cnt, 1);
      chk("t2_sel_bubble", hu.fwd_sel, 0);
      chk("t2_stall_once", hu.stall, 0);
      tick();
      chk("t2_sel", hu.fwd_sel, 4'h3);
      chk("t2_opnd0", hu.ex_opnd[15:0], 16'h0043);
      chk("t2_fcnt", hu.fwd_cnt, 2);

      // Youngest wins: r5 written again, then read on operand 1
      id_set(1, 0, 0, 2'b00, 5, 1, 0); tick();
      id_set(1, 0, 5, 2'b10, 6, 1, 0); #1;
      chk("t3_stall", hu.stall, 0);
      tick();
      chk("t3_sel", hu.fwd_sel, 4'h8);
      chk("t3_opnd1", hu.ex_opnd[31:16], 16'h0042);
      chk("t3_fcnt", hu.fwd_cnt, 3);

      // Flush coincident with a load-use hazard; flushed r7 writer must vanish
      id_set(1, 0, 0, 2'b00, 4, 1, 1); tick();
      id_set(1, 4, 0, 2'b01, 7, 1, 0);
      hu.flush_id = 1'b1; #1;
      chk("t4_stall", hu.stall, 0);
      tick();
      hu.flush_id = 1'b0;
      chk("t4_sel", hu.fwd_sel, 0);
      chk("t4_scnt", hu.stall_cnt, 1);
      id_set(1, 4, 7, 2'b11, 0, 0, 0); #1;
      chk("t4_stall_after", hu.stall, 0);
      tick();
      chk("t4_sel2", hu.fwd_sel, 4'h3);
      chk("t4_opnd0", hu.ex_opnd[15:0], 16'h0043);
      chk("t4_opnd1", hu.ex_opnd[31:16], 16'h2000);
      chk("t4_fcnt", hu.fwd_cnt, 4);

      // Freeze for 3 cycles over a load-use, then release
      id_set(1, 0, 0, 2'b00, 4, 1, 1); tick();
      id_set(1, 4, 0, 2'b01, 0, 0, 0);
      hu.freeze = 1'b1; #1;
      chk("t5_stall_frz", hu.stall, 0);
      repeat (3) begin
         tick();
         chk("t5_frz_stall", hu.stall, 0);
         chk("t5_frz_scnt", hu.stall_cnt, 1);
         chk("t5_frz_fcnt", hu.fwd_cnt, 4);
         chk("t5_frz_sel", hu.fwd_sel, 0);
      end
      hu.freeze = 1'b0; #1;
      chk("t5_stall_rel", hu.stall, 1);
      tick();
      chk("t5_scnt", hu.stall_cnt, 2);
      chk("t5_stall_once", hu.stall, 0);
      tick();
      chk("t5_sel", hu.fwd_sel, 4'h3);
      chk("t5_fcnt", hu.fwd_cnt, 5);

      // Reset while stalled
      id_set(1, 0, 0, 2'b00, 4, 1, 1); tick();
      id_set(1, 4, 0, 2'b01, 0, 0, 0); #1;
      chk("t6_stall_pre", hu.stall, 1);
      reset = 1'b1;
      tick();
      chk("t6_stall", hu.stall, 0);
      chk("t6_sel", hu.fwd_sel, 0);
      chk("t6_scnt", hu.stall_cnt, 0);
      chk("t6_fcnt", hu.fwd_cnt, 0);
      reset = 1'b0;

      // Saturation: r1 = r1 + r1 every cycle forwards both operands
      id_set(1, 1, 1, 2'b11, 1, 1, 0); tick();
      repeat (100) tick();
      chk("sat_mid", hu.fwd_cnt, 200);
      repeat (32800) tick();
      chk("sat_fcnt", hu.fwd_cnt, 16'hFFFF);
      tick();
      chk("sat_hold", hu.fwd_cnt, 16'hFFFF);
      chk("sat_scnt", hu.stall_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
